// File: rtl/pll_seq_pkg.sv
// ----------------------------------------------------------------------------
// pll_seq_pkg
//
// Shared definitions for the iCEstick PLL reset sequencer (pll_rst_seq):
//   - FSM state encoding (3-bit)
//   - default timing constants for the 12 MHz reference clock
//   - output bundle type and the Moore output decode used by the FSM
//
// No ports (package).
// ----------------------------------------------------------------------------
package pll_seq_pkg;

    // Sequencer states. The numeric values are fixed so that state dumps from
    // hardware can be read back directly.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        STABLE    = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_state_t;

    // Default timing for a 12 MHz reference (83.3 ns per cycle).
    localparam int DEF_RST_CYCLES    = 12;    // 1 us RESETB pulse
    localparam int DEF_LOCK_TIMEOUT  = 1200;  // 100 us to acquire lock
    localparam int DEF_STABLE_CYCLES = 120;   // 10 us of continuous lock
    localparam int DEF_MAX_RETRY     = 3;     // lock timeouts before FAULT
    localparam int DEF_CNT_W         = 16;    // shared timer width

    // Width of the lock-loss event counter port.
    localparam int LOSS_CNT_W = 8;

    // Registered outputs that are a pure function of state.
    typedef struct packed {
        logic pll_resetb;
        logic sys_rst_n;
        logic ready;
        logic fault;
    } pll_out_t;

    // Moore decode. The FSM feeds this with the next state so that the
    // outputs change on the same edge as the state register.
    function automatic pll_out_t decode_outputs(input pll_state_t s);
        pll_out_t o;
        o = '0;
        case (s)
            IDLE, PLL_RST: begin
                o.pll_resetb = 1'b0;
            end
            WAIT_LOCK, STABLE: begin
                o.pll_resetb = 1'b1;
            end
            RUN: begin
                o.pll_resetb = 1'b1;
                o.sys_rst_n  = 1'b1;
                o.ready      = 1'b1;
            end
            FAULT: begin
                o.pll_resetb = 1'b0;
                o.fault      = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//
// Generic 1-bit two-flop synchroniser with asynchronous active-low reset.
// The output reads 0 while in reset.
//
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset
//   d      in  1  asynchronous input
//   q      out 1  synchronised output (two clk edges of latency)
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // stage_reg[0] may go metastable; stage_reg[1] gets a full cycle to settle.
    logic [1:0] stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= 2'b00;
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/pll_rst_seq.sv
// ----------------------------------------------------------------------------
// pll_rst_seq
//
// Bring-up and supervision controller for the iCEstick PLL (12 MHz -> 96 MHz).
// Pulses the PLL RESETB input, waits for LOCK, demands that lock be stable for
// STABLE_CYCLES before releasing the system reset, retries on lock timeout,
// restarts the PLL on lock loss and raises fault after MAX_RETRY timeouts.
// Everything runs on the free-running 12 MHz reference clock.
//
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN
//   defined   : lock_loss_cnt counts lock-loss events in RUN (saturates at 255)
//   undefined : no counter, lock_loss_cnt is tied to 0 (same port list)
//
// Parameters:
//   RST_CYCLES     clk cycles RESETB is held low per PLL reset pulse
//   LOCK_TIMEOUT   clk cycles allowed in WAIT_LOCK before a retry
//   STABLE_CYCLES  consecutive locked cycles required before release
//   MAX_RETRY      lock timeouts tolerated before FAULT (>= 1)
//   CNT_W          timer width, 2^CNT_W > max of the three cycle counts
//
// Ports:
//   clk            in  1  12 MHz reference clock (PLL ref_clk net)
//   rst_n          in  1  asynchronous active-low reset
//   enable         in  1  level; 1 = run sequence, 0 = return to IDLE
//   pll_locked     in  1  PLL LOCK, asynchronous to clk
//   pll_resetb     out 1  PLL RESETB; 0 holds the PLL in reset
//   sys_rst_n      out 1  system reset release (clk domain)
//   ready          out 1  1 while in RUN
//   fault          out 1  1 while in FAULT
//   lock_loss_cnt  out 8  lock-loss events seen in RUN
// ----------------------------------------------------------------------------
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  pll_locked,
    output logic                  pll_resetb,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  fault,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    // Retry counter only needs to reach MAX_RETRY.
    localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    // Terminal timer values: each phase lasts exactly N cycles, so the
    // transition fires while the timer shows N-1.
    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    // ------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------
    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // ------------------------------------------------------------------
    // State, timer and retry bookkeeping
    // ------------------------------------------------------------------
    pll_state_t         state_reg;
    pll_state_t         state_next;
    logic [CNT_W-1:0]   timer_reg;
    logic [CNT_W-1:0]   timer_next;
    logic [RETRY_W-1:0] retry_reg;
    logic [RETRY_W-1:0] retry_next;
    logic [RETRY_W-1:0] retry_inc;
    logic [CNT_W-1:0]   timer_inc;
    pll_out_t           out_next;

    assign retry_inc = retry_reg + RETRY_W'(1);
    assign timer_inc = timer_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        timer_next = timer_inc;
        retry_next = retry_reg;

        if (!enable) begin
            // Dropping enable aborts from anywhere and forgets past timeouts.
            state_next = IDLE;
            timer_next = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = PLL_RST;
                    timer_next = '0;
                end

                PLL_RST: begin
                    if (timer_reg == RST_LAST) begin
                        state_next = WAIT_LOCK;
                        timer_next = '0;
                    end
                end

                WAIT_LOCK: begin
                    // Lock is checked first so a lock arriving on the
                    // timeout cycle is accepted rather than retried.
                    if (lock_s) begin
                        state_next = STABLE;
                        timer_next = '0;
                    end else if (timer_reg == LOCK_LAST) begin
                        timer_next = '0;
                        retry_next = retry_inc;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_next = FAULT;
                        end else begin
                            state_next = PLL_RST;
                        end
                    end
                end

                STABLE: begin
                    // A lock dropout restarts the stability window without
                    // counting as a retry.
                    if (!lock_s) begin
                        state_next = WAIT_LOCK;
                        timer_next = '0;
                    end else if (timer_reg == STABLE_LAST) begin
                        state_next = RUN;
                        timer_next = '0;
                        retry_next = '0;
                    end
                end

                RUN: begin
                    timer_next = '0;
                    if (!lock_s) begin
                        state_next = PLL_RST;
                    end
                end

                FAULT: begin
                    timer_next = '0;
                end

                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                    retry_next = '0;
                end
            endcase
        end
    end

    assign out_next = decode_outputs(state_next);

    // Outputs are registered from the next-state decode so they switch on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            retry_reg  <= '0;
            pll_resetb <= 1'b0;
            sys_rst_n  <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            retry_reg  <= retry_next;
            pll_resetb <= out_next.pll_resetb;
            sys_rst_n  <= out_next.sys_rst_n;
            ready      <= out_next.ready;
            fault      <= out_next.fault;
        end
    end

    // ------------------------------------------------------------------
    // Lock-loss event counter
    // ------------------------------------------------------------------
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic                  loss_event;
    logic [LOSS_CNT_W-1:0] loss_cnt_reg;

    // Same condition as the RUN -> PLL_RST transition, so the count updates
    // on the edge where ready falls.
    assign loss_event = enable && (state_reg == RUN) && !lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_reg <= '0;
        end else if (loss_event && (loss_cnt_reg != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_reg <= loss_cnt_reg + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_cnt = loss_cnt_reg;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_pll_rst_seq
//
// Self-checking bench for pll_rst_seq with short timing parameters.
// Each stimulus task pushes the expected output vector for every cycle it
// covers into a scoreboard queue; a negedge monitor pops and compares.
// Output vector: {pll_resetb, sys_rst_n, ready, fault, lock_loss_cnt[7:0]}.
// ----------------------------------------------------------------------------
module tb_pll_rst_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 16;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;

`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pll_locked;
    logic       pll_resetb;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_cnt;

    always #5 clk = ~clk;

    pll_rst_seq #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pll_locked    (pll_locked),
        .pll_resetb    (pll_resetb),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fault         (fault),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int exp_loss = 0;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        string       tag;
        logic [11:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    task automatic expect_range(input int c0, input int c1, input string tag, input logic [11:0] v);
        sb_item_t it;
        for (int c = c0; c <= c1; c++) begin
            it.cyc = c;
            it.tag = tag;
            it.exp = v;
            sb.push_back(it);
        end
    endtask

    always @(negedge clk) begin
        sb_item_t it;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            check($sformatf("%s@%0d", it.tag, it.cyc),
                  {pll_resetb, sys_rst_n, ready, fault, lock_loss_cnt}, it.exp);
        end
    end

    // ---------------- expected vectors ----------------
    function automatic int shown(input int n);
        return LOSS_EN ? n : 0;
    endfunction

    function automatic logic [11:0] ov(input logic rb, input logic sr, input logic rd,
                                       input logic ft, input int cnt);
        return {rb, sr, rd, ft, 8'(cnt)};
    endfunction

    function automatic logic [11:0] o_rst(input int cnt);   return ov(1'b0, 1'b0, 1'b0, 1'b0, cnt); endfunction
    function automatic logic [11:0] o_wl(input int cnt);    return ov(1'b1, 1'b0, 1'b0, 1'b0, cnt); endfunction
    function automatic logic [11:0] o_run(input int cnt);   return ov(1'b1, 1'b1, 1'b1, 1'b0, cnt); endfunction
    function automatic logic [11:0] o_fault(input int cnt); return ov(1'b0, 1'b0, 1'b0, 1'b1, cnt); endfunction

    // Returns at posedge(c)+1; inputs set afterwards are sampled at edge c+1.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- scenarios ----------------
    // From IDLE with lock low: lock rises 5 cycles after RESETB rises.
    task automatic bring_up(input string tag);
        int c0, r, s, run_e, cnt;
        c0 = cyc; cnt = shown(exp_loss);
        r = c0 + RST_CYCLES + 1;
        s = r + 5;
        run_e = s + STABLE_CYCLES + 2;
        enable = 1'b1;
        expect_range(c0 + 1, r - 1, {tag, "_pll_rst"}, o_rst(cnt));
        expect_range(r, run_e - 1, {tag, "_wait"}, o_wl(cnt));
        expect_range(run_e, run_e + 1, {tag, "_run"}, o_run(cnt));
        wait_until(s - 1);
        pll_locked = 1'b1;
        wait_until(run_e + 1);
        $display("[%0d] %s: released at edge %0d", cyc, tag, run_e);
    endtask

    task automatic go_idle();
        int t;
        t = cyc;
        enable = 1'b0;
        pll_locked = 1'b0;
        expect_range(t + 1, t + 3, "idle", o_rst(shown(exp_loss)));
        wait_until(t + 3);
        $display("[%0d] idle", cyc);
    endtask

    // Lock dropout of 3 sampled cycles starting at STABLE timer = 5.
    task automatic glitch_stable();
        int c0, r, s, e, d, b, s2, run_e, cnt;
        c0 = cyc; cnt = shown(exp_loss);
        r = c0 + RST_CYCLES + 1;
        s = r + 5;
        e = s + 2;
        d = e + 5;
        b = d + 3;
        s2 = b + 1;
        run_e = s2 + STABLE_CYCLES + 2;
        enable = 1'b1;
        expect_range(c0 + 1, r - 1, "glitch_pll_rst", o_rst(cnt));
        expect_range(r, run_e - 1, "glitch_wait", o_wl(cnt));
        expect_range(run_e, run_e + 1, "glitch_run", o_run(cnt));
        wait_until(s - 1);
        pll_locked = 1'b1;
        wait_until(d);
        pll_locked = 1'b0;
        wait_until(b);
        pll_locked = 1'b1;
        wait_until(run_e + 1);
        $display("[%0d] glitch: released at edge %0d", cyc, run_e);
    endtask

    // Lock never arrives: two pulses, FAULT, then enable low clears it.
    task automatic timeout_fault();
        int c0, r1, t1, r2, t2, cnt;
        c0 = cyc; cnt = shown(exp_loss);
        r1 = c0 + RST_CYCLES + 1;
        t1 = r1 + LOCK_TIMEOUT;
        r2 = t1 + RST_CYCLES;
        t2 = r2 + LOCK_TIMEOUT;
        enable = 1'b1;
        expect_range(c0 + 1, r1 - 1, "to_pulse1", o_rst(cnt));
        expect_range(r1, t1 - 1, "to_wait1", o_wl(cnt));
        expect_range(t1, r2 - 1, "to_pulse2", o_rst(cnt));
        expect_range(r2, t2 - 1, "to_wait2", o_wl(cnt));
        expect_range(t2, t2 + 3, "to_fault", o_fault(cnt));
        expect_range(t2 + 4, t2 + 5, "to_idle", o_rst(cnt));
        wait_until(t2 + 3);
        enable = 1'b0;
        wait_until(t2 + 5);
        $display("[%0d] timeout: fault at edge %0d cleared", cyc, t2);
    endtask

    // After FAULT the retry count must be clear: one timeout retries, not faults.
    task automatic retry_clear();
        int c0, r1, t1, r2, s, run_e, cnt;
        c0 = cyc; cnt = shown(exp_loss);
        r1 = c0 + RST_CYCLES + 1;
        t1 = r1 + LOCK_TIMEOUT;
        r2 = t1 + RST_CYCLES;
        s = r2 + 5;
        run_e = s + STABLE_CYCLES + 2;
        enable = 1'b1;
        expect_range(c0 + 1, r1 - 1, "rc_pulse1", o_rst(cnt));
        expect_range(r1, t1 - 1, "rc_wait1", o_wl(cnt));
        expect_range(t1, r2 - 1, "rc_pulse2", o_rst(cnt));
        expect_range(r2, run_e - 1, "rc_wait2", o_wl(cnt));
        expect_range(run_e, run_e + 1, "rc_run", o_run(cnt));
        wait_until(s - 1);
        pll_locked = 1'b1;
        wait_until(run_e + 1);
        $display("[%0d] retry after fault: released at edge %0d", cyc, run_e);
    endtask

    // Synchronised lock first seen exactly on the timeout cycle: lock wins.
    task automatic lock_on_timeout();
        int c0, r, tt, s, run_e, cnt;
        c0 = cyc; cnt = shown(exp_loss);
        r = c0 + RST_CYCLES + 1;
        tt = r + LOCK_TIMEOUT;
        s = tt - 2;
        run_e = tt + STABLE_CYCLES;
        enable = 1'b1;
        expect_range(c0 + 1, r - 1, "lot_pll_rst", o_rst(cnt));
        expect_range(r, run_e - 1, "lot_wait", o_wl(cnt));
        expect_range(run_e, run_e + 1, "lot_run", o_run(cnt));
        wait_until(s - 1);
        pll_locked = 1'b1;
        wait_until(run_e + 1);
        $display("[%0d] lock on timeout: released at edge %0d", cyc, run_e);
    endtask

    // From RUN: lock falls, PLL restarted, lock returns, back in RUN.
    task automatic lose_and_relock();
        int t, r, s, run_e, cb, ca;
        t = cyc;
        cb = shown(exp_loss);
        if (exp_loss < 255) exp_loss++;
        ca = shown(exp_loss);
        pll_locked = 1'b0;
        r = t + 3 + RST_CYCLES;
        s = r + 5;
        run_e = s + STABLE_CYCLES + 2;
        expect_range(t + 1, t + 2, "loss_hold", o_run(cb));
        expect_range(t + 3, r - 1, "loss_pll_rst", o_rst(ca));
        expect_range(r, run_e - 1, "loss_wait", o_wl(ca));
        expect_range(run_e, run_e, "loss_rerun", o_run(ca));
        wait_until(s - 1);
        pll_locked = 1'b1;
        wait_until(run_e);
        $display("[%0d] lock loss event, model count %0d", cyc, exp_loss);
    endtask

    // From RUN: lose lock, re-lock, then pull rst_n low in STABLE.
    task automatic reset_mid_stable();
        int t, r, s, cb, ca;
        t = cyc;
        cb = shown(exp_loss);
        if (exp_loss < 255) exp_loss++;
        ca = shown(exp_loss);
        pll_locked = 1'b0;
        r = t + 3 + RST_CYCLES;
        s = r + 5;
        expect_range(t + 1, t + 2, "rs_hold", o_run(cb));
        expect_range(t + 3, r - 1, "rs_pll_rst", o_rst(ca));
        expect_range(r, s + 3, "rs_wait", o_wl(ca));
        wait_until(s - 1);
        pll_locked = 1'b1;
        wait_until(s + 4);        // STABLE, timer = 2
        rst_n = 1'b0;
        exp_loss = 0;
        expect_range(s + 4, s + 5, "rs_async", o_rst(0));
        wait_until(s + 5);
        enable = 1'b0;
        rst_n = 1'b1;
        expect_range(s + 6, s + 7, "rs_after", o_rst(0));
        wait_until(s + 7);
        $display("[%0d] reset asserted in STABLE at edge %0d", cyc, s + 4);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        pll_locked = 1'b0;

        wait_until(2);
        expect_range(2, 3, "reset", o_rst(0));
        wait_until(3);
        rst_n = 1'b1;
        expect_range(4, 5, "idle_after_reset", o_rst(0));
        wait_until(5);
        $display("[%0d] reset released", cyc);

        bring_up("bringup");
        go_idle();
        glitch_stable();
        lose_and_relock();
        go_idle();
        timeout_fault();
        retry_clear();
        go_idle();
        lock_on_timeout();
        for (int i = 0; i < 259; i++) begin
            lose_and_relock();
        end
        reset_mid_stable();

        @(negedge clk);
        #1;
        check("scoreboard_drained", 12'(sb.size()), 12'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
